bus_bridge_initiator_if: RTL and testbench
==========================================

BUS_BRIDGE_INITIATOR_IF -- requirements
Module: bus_bridge_initiator_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd1023, max cycles waited for target ack/split data before forced completion.
REQ-002 Parameter TIMEOUT_RDATA, default 8'hFF, read_data returned on timeout.
REQ-003 Clocking and reset: reset rst_n, asynchronous, active-low; clock clk.
REQ-004 clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-005 req_valid  in  1  request from bridge target side; req_ready  out  1  request accepted; req_payload  in  bus_bridge_req_t  {is_write, addr[15:0], write_data[7:0]}.
REQ-006 resp_valid  out  1  response available; resp_ready  in  1  consumer accepts; resp_payload  out  bus_bridge_resp_t  {is_write, read_data[7:0]}.
REQ-007 m_req  out  1  bus-B arbiter request; m_grant  in  1  arbiter grant.
REQ-008 m_address_out  out  16  address; m_address_out_valid  out  1  address phase; m_rw  out  1  1=write; m_data_out  out  8  write data; m_data_out_valid  out  1  write data phase.
REQ-009 m_ready  in  1  target ready; m_ack  in  1  completion; m_split_ack  in  1  target split; m_data_in  in  8  read data; m_data_in_valid  in  1  read data valid.

Function
REQ-010 States IDLE, ARB, ADDR, WAIT, SPLIT_WAIT, RESP; single-entry buffer, one transaction in flight.
REQ-011 req_ready SHALL be combinational, 1 only in IDLE; req_valid&&req_ready latches req_payload, IDLE->ARB next cycle.
REQ-012 ARB: m_req=1; on m_grant sampled high -> ADDR; no timeout in ARB.
REQ-013 ADDR: drive m_address_out/m_rw/m_address_out_valid=1, plus m_data_out/m_data_out_valid=1 when write; hold until m_ready=1 sampled, then -> WAIT with valids deasserted next cycle.
REQ-014 m_req SHALL stay 1 from ARB through WAIT; grant deassertion after ARB is ignored.
REQ-015 WAIT: m_ack -> RESP with resp is_write=latched is_write, read_data=m_data_in if read (m_data_in_valid qualifies), 8'h00 if write.
REQ-016 WAIT: m_split_ack without m_ack -> SPLIT_WAIT, m_req deasserted; m_ack and m_split_ack same cycle: m_ack wins.
REQ-017 SPLIT_WAIT: m_req=0; on m_ack (with m_data_in_valid for read) -> RESP capturing m_data_in.
REQ-018 16-bit timeout counter cleared on entry to WAIT and SPLIT_WAIT, increments each cycle there; reaching TIMEOUT_CYCLES -> RESP with read_data=TIMEOUT_RDATA (read) or 8'h00 (write), m_req=0.
REQ-019 RESP: resp_valid=1 registered, payload stable until resp_valid&&resp_ready; then -> IDLE, resp_valid=0 next cycle; m_req=0.
REQ-020 resp_ready low indefinitely SHALL hold RESP with no new request accepted.
REQ-021 Minimum latency req accept to resp_valid with immediate grant, ready, ack: 4 cycles.

Reset
REQ-022 Async reset SHALL force state IDLE; req_ready, resp_valid, m_req, all valids, m_rw = 0; m_address_out, m_data_out, resp_payload, counter, buffer = 0.
REQ-023 Reset mid-transaction SHALL drop it silently; no response after reset release.

Structure
REQ-024 bus_bridge_req_t and bus_bridge_resp_t SHALL come from bus_bridge_pkg; state enum local.
REQ-025 No sub-module; timeout counter inline.

Verification
REQ-026 Write req addr 16'h4010 data 8'hA5, immediate grant/ready, ack in WAIT -> one m_address_out_valid cycle with m_rw=1, m_data_out=8'hA5, resp is_write=1.
REQ-027 Read 16'h0020, grant delayed 5 cycles, ack with m_data_in=8'h3C -> m_req held 5+ cycles, resp read_data=8'h3C.
REQ-028 Read with m_split_ack then ack with 8'h77 after 20 cycles -> m_req drops on split, resp read_data=8'h77.
REQ-029 Read, no ack -> resp after TIMEOUT_CYCLES with read_data=8'hFF; m_ack+m_split_ack same cycle -> direct RESP.
REQ-030 resp_ready low 10 cycles with req_valid high -> req_ready stays 0, payload stable; assert rst_n low in WAIT -> all outputs 0, no resp.

Source files
------------

// File: rtl/bus_bridge_pkg.sv
// rtl/bus_bridge_pkg.sv - shared request/response payload types for the bus bridge
//
// Purpose: payload structs exchanged between the bridge target side and the
//          bus-B initiator, plus the address/data widths they are built from.
// Ports:   none (package).

package bus_bridge_pkg;

    localparam int BB_ADDR_W = 16;
    localparam int BB_DATA_W = 8;

    typedef struct packed {
        logic                 is_write;
        logic [BB_ADDR_W-1:0] addr;
        logic [BB_DATA_W-1:0] write_data;
    } bus_bridge_req_t;

    typedef struct packed {
        logic                 is_write;
        logic [BB_DATA_W-1:0] read_data;
    } bus_bridge_resp_t;

endpackage

// File: rtl/bus_bridge_initiator_if.sv
// rtl/bus_bridge_initiator_if.sv - single-outstanding bus-B initiator for the bus bridge
//
// Purpose: accepts one request from the bridge target side, arbitrates for
//          bus B, runs the address/data phase, waits for completion (direct
//          ack, split completion or timeout) and returns one response.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_payload request handshake from the target side
//   resp_valid/resp_ready/resp_payload response handshake to the target side
//   m_req/m_grant                   bus-B arbitration
//   m_address_out(_valid), m_rw     address phase (m_rw=1 is write)
//   m_data_out(_valid)              write data phase
//   m_ready, m_ack, m_split_ack     target ready / completion / split
//   m_data_in(_valid)               read data from the target

module bus_bridge_initiator_if
    import bus_bridge_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1023,
    parameter logic [7:0]  TIMEOUT_RDATA  = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  bus_bridge_req_t  req_payload,

    output logic             resp_valid,
    input  logic             resp_ready,
    output bus_bridge_resp_t resp_payload,

    output logic             m_req,
    input  logic             m_grant,

    output logic [15:0]      m_address_out,
    output logic             m_address_out_valid,
    output logic             m_rw,
    output logic [7:0]       m_data_out,
    output logic             m_data_out_valid,

    input  logic             m_ready,
    input  logic             m_ack,
    input  logic             m_split_ack,
    input  logic [7:0]       m_data_in,
    input  logic             m_data_in_valid
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ADDR,
        ST_WAIT,
        ST_SPLIT_WAIT,
        ST_RESP
    } state_t;

    state_t          state;
    bus_bridge_req_t req_buf;
    logic [15:0]     tmo_cnt;
    logic            ack_done;
    logic            cnt_hit;

    // Gated by rst_n so the handshake reads 0 while reset is asserted.
    assign req_ready = rst_n && (state == ST_IDLE);

    // A read only completes when the ack comes with valid read data.
    assign ack_done  = m_ack && (req_buf.is_write || m_data_in_valid);

    // The counter starts at 0 on entry, so the last waiting cycle sees
    // TIMEOUT_CYCLES-1; completing there gives exactly TIMEOUT_CYCLES cycles.
    assign cnt_hit   = (tmo_cnt == (TIMEOUT_CYCLES - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            req_buf             <= '0;
            tmo_cnt             <= '0;
            resp_valid          <= 1'b0;
            resp_payload        <= '0;
            m_req               <= 1'b0;
            m_address_out       <= '0;
            m_address_out_valid <= 1'b0;
            m_rw                <= 1'b0;
            m_data_out          <= '0;
            m_data_out_valid    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_buf <= req_payload;
                        m_req   <= 1'b1;
                        state   <= ST_ARB;
                    end
                end

                ST_ARB: begin
                    if (m_grant) begin
                        m_address_out       <= req_buf.addr;
                        m_address_out_valid <= 1'b1;
                        m_rw                <= req_buf.is_write;
                        if (req_buf.is_write) begin
                            m_data_out       <= req_buf.write_data;
                            m_data_out_valid <= 1'b1;
                        end
                        state <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    // m_req stays high here even if the grant is withdrawn.
                    if (m_ready) begin
                        m_address_out_valid <= 1'b0;
                        m_data_out_valid    <= 1'b0;
                        m_rw                <= 1'b0;
                        tmo_cnt             <= '0;
                        state               <= ST_WAIT;
                    end
                end

                ST_WAIT, ST_SPLIT_WAIT: begin
                    if (ack_done) begin
                        // Checked before split so a simultaneous ack wins.
                        resp_payload.is_write  <= req_buf.is_write;
                        resp_payload.read_data <= req_buf.is_write ? 8'h00 : m_data_in;
                        resp_valid             <= 1'b1;
                        m_req                  <= 1'b0;
                        state                  <= ST_RESP;
                    end else if ((state == ST_WAIT) && m_split_ack) begin
                        m_req   <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= ST_SPLIT_WAIT;
                    end else if (cnt_hit) begin
                        resp_payload.is_write  <= req_buf.is_write;
                        resp_payload.read_data <= req_buf.is_write ? 8'h00 : TIMEOUT_RDATA;
                        resp_valid             <= 1'b1;
                        m_req                  <= 1'b0;
                        state                  <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_bridge_initiator_if.sv
// tb/tb_bus_bridge_initiator_if.sv - directed self-checking bench for bus_bridge_initiator_if

module tb_bus_bridge_initiator_if;
    import bus_bridge_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    bus_bridge_req_t  req_payload;
    logic             resp_valid;
    logic             resp_ready;
    bus_bridge_resp_t resp_payload;
    logic             m_req;
    logic             m_grant;
    logic [15:0]      m_address_out;
    logic             m_address_out_valid;
    logic             m_rw;
    logic [7:0]       m_data_out;
    logic             m_data_out_valid;
    logic             m_ready;
    logic             m_ack;
    logic             m_split_ack;
    logic [7:0]       m_data_in;
    logic             m_data_in_valid;

    int n_cmp;
    int n_bad;

    // Observations collected by wait_resp.
    int          lat;
    int          n_addr;
    int          n_mreq;
    logic        s_rw;
    logic [15:0] s_addr;
    logic [7:0]  s_d;
    logic        s_dv;

    bus_bridge_initiator_if dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_payload         (req_payload),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_payload        (resp_payload),
        .m_req               (m_req),
        .m_grant             (m_grant),
        .m_address_out       (m_address_out),
        .m_address_out_valid (m_address_out_valid),
        .m_rw                (m_rw),
        .m_data_out          (m_data_out),
        .m_data_out_valid    (m_data_out_valid),
        .m_ready             (m_ready),
        .m_ack               (m_ack),
        .m_split_ack         (m_split_ack),
        .m_data_in           (m_data_in),
        .m_data_in_valid     (m_data_in_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        m_grant         = 1'b0;
        m_ready         = 1'b0;
        m_ack           = 1'b0;
        m_split_ack     = 1'b0;
        m_data_in       = 8'h00;
        m_data_in_valid = 1'b0;
    endtask

    // Presents one request in IDLE; returns just after the accepting edge.
    task automatic send_req(input string tag, input logic wr, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        req_payload = '{is_write: wr, addr: a, write_data: d};
        req_valid   = 1'b1;
        check({tag, "_req_ready"}, req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // lat counts posedges including the accepting one, so the minimum is 4.
    task automatic wait_resp(input int limit);
        bit done;
        done   = 0;
        lat    = 1;
        n_addr = 0;
        n_mreq = 0;
        s_rw   = 1'b0;
        s_addr = '0;
        s_d    = '0;
        s_dv   = 1'b0;
        while (!done && lat < limit) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (m_address_out_valid) begin
                n_addr++;
                s_rw   = m_rw;
                s_addr = m_address_out;
                s_d    = m_data_out;
                s_dv   = m_data_out_valid;
            end
            if (m_req) n_mreq++;
            if (resp_valid) done = 1;
        end
    endtask

    task automatic finish_resp(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_resp_drop"}, resp_valid, 1'b0);
        check({tag, "_idle_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_payload = '0;
        resp_ready  = 1'b0;
        bus_idle();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs",
              {req_ready, resp_valid, resp_payload, m_req, m_address_out,
               m_address_out_valid, m_rw, m_data_out, m_data_out_valid}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", req_ready, 1'b1);

        // Write with immediate grant/ready/ack: minimum latency
        m_grant = 1'b1; m_ready = 1'b1; m_ack = 1'b1;
        send_req("wr", 1'b1, 16'h4010, 8'hA5);
        wait_resp(20);
        check("wr_latency", lat, 4);
        check("wr_addr_cycles", n_addr, 1);
        check("wr_rw", s_rw, 1'b1);
        check("wr_addr", s_addr, 16'h4010);
        check("wr_data", s_d, 8'hA5);
        check("wr_data_valid", s_dv, 1'b1);
        check("wr_resp", {resp_valid, resp_payload}, {1'b1, 1'b1, 8'h00});
        finish_resp("wr");

        // Read with grant delayed 5 cycles
        bus_idle();
        m_ready = 1'b1; m_ack = 1'b1; m_data_in = 8'h3C; m_data_in_valid = 1'b1;
        send_req("rd_dly", 1'b0, 16'h0020, 8'h00);
        fork
            wait_resp(40);
            begin
                repeat (5) @(negedge clk);
                m_grant = 1'b1;
            end
        join
        check("rd_dly_latency", lat, 8);
        check("rd_dly_mreq_cycles", n_mreq, 6);
        check("rd_dly_rw", s_rw, 1'b0);
        check("rd_dly_addr", s_addr, 16'h0020);
        check("rd_dly_resp", {resp_valid, resp_payload}, {1'b1, 1'b0, 8'h3C});
        finish_resp("rd_dly");

        // Split, then completion 20 cycles later
        bus_idle();
        m_grant = 1'b1; m_ready = 1'b1; m_split_ack = 1'b1;
        send_req("split", 1'b0, 16'h1234, 8'h00);
        fork
            wait_resp(100);
            begin
                repeat (3) @(negedge clk);
                check("split_mreq_wait", m_req, 1'b1);
                @(negedge clk);
                check("split_mreq_drop", m_req, 1'b0);
                m_split_ack = 1'b0;
                repeat (20) @(negedge clk);
                m_ack = 1'b1; m_data_in = 8'h77; m_data_in_valid = 1'b1;
            end
        join
        check("split_latency", lat, 25);
        check("split_resp", {resp_valid, resp_payload}, {1'b1, 1'b0, 8'h77});
        finish_resp("split");

        // Read with no ack: timeout completion
        bus_idle();
        m_grant = 1'b1; m_ready = 1'b1;
        send_req("tmo", 1'b0, 16'h0BAD, 8'h00);
        wait_resp(1200);
        check("tmo_latency", lat, 3 + 1023);
        check("tmo_mreq", m_req, 1'b0);
        check("tmo_resp", {resp_valid, resp_payload}, {1'b1, 1'b0, 8'hFF});
        finish_resp("tmo");

        // ack and split in the same cycle: ack wins, no split
        bus_idle();
        m_grant = 1'b1; m_ready = 1'b1; m_ack = 1'b1; m_split_ack = 1'b1;
        m_data_in = 8'h5A; m_data_in_valid = 1'b1;
        send_req("both", 1'b0, 16'h00F0, 8'h00);
        wait_resp(20);
        check("both_latency", lat, 4);
        check("both_mreq_cycles", n_mreq, 2);
        check("both_resp", {resp_valid, resp_payload}, {1'b1, 1'b0, 8'h5A});

        // Hold resp_ready low 10 cycles with a new request pending
        begin
            int bad_rdy;
            int bad_pay;
            bad_rdy = 0;
            bad_pay = 0;
            req_payload = '{is_write: 1'b1, addr: 16'hFFFF, write_data: 8'h11};
            req_valid   = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (req_ready !== 1'b0) bad_rdy++;
                if ({resp_valid, resp_payload} !== {1'b1, 1'b0, 8'h5A}) bad_pay++;
            end
            check("stall_req_ready_cycles", bad_rdy, 0);
            check("stall_payload_cycles", bad_pay, 0);
            check("stall_mreq", m_req, 1'b0);
            req_valid = 1'b0;
        end
        finish_resp("stall");

        // Reset asserted while in WAIT
        bus_idle();
        m_grant = 1'b1; m_ready = 1'b1;
        send_req("rstw", 1'b1, 16'h0055, 8'hC3);
        repeat (3) @(negedge clk);
        check("rstw_in_wait_mreq", m_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstw_outputs",
              {req_ready, resp_valid, resp_payload, m_req, m_address_out,
               m_address_out_valid, m_rw, m_data_out, m_data_out_valid}, 64'd0);
        m_ack = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int stray;
            stray = 0;
            repeat (10) begin
                @(negedge clk);
                if (resp_valid || m_req) stray++;
            end
            check("rstw_no_resp_cycles", stray, 0);
        end
        check("rstw_idle_ready", req_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
